// File: rtl/hub75_panel_capture.sv
// HUB75 panel receiver: oversamples panel pins, rebuilds shifted rows and
// commits them into a readable frame store on the output-enable falling edge.
module hub75_panel_capture #(
  parameter int COLS        = 64,
  parameter int SCAN        = 16,
  parameter int ADDR_W      = 4,
  parameter int COL_W       = 6,
  parameter int COMMIT_ONCE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              P_R1,
  input  logic              P_G1,
  input  logic              P_B1,
  input  logic              P_R2,
  input  logic              P_G2,
  input  logic              P_B2,
  input  logic [ADDR_W-1:0] P_ADDR,
  input  logic              P_CLK,
  input  logic              P_STB,
  input  logic              P_OEB,
  input  logic [ADDR_W:0]   rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [2:0]        rd_rgb,
  output logic              row_commit,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  output logic [15:0]       commit_count
);

  localparam int SW    = ADDR_W + 9;
  localparam int DOFS  = ADDR_W + 3;
  localparam int CNT_W = $clog2(COLS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(COLS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(COLS + 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W:0]    COL_LIM  = (COL_W + 1)'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(SCAN - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  // Bit layout: [0]=OEB [1]=STB [2]=CLK, then address, then R1,G1,B1,R2,G2,B2.
  logic [SW-1:0] pins, s1, s2;
  logic [2:0]    s3;

  assign pins = {P_B2, P_G2, P_R2, P_B1, P_G1, P_R1, P_ADDR, P_CLK, P_STB, P_OEB};

  logic              clk_rise, stb_rise, oeb_fall, commit;
  logic [ADDR_W-1:0] row_a;
  logic [5:0]        din;

  assign clk_rise = s2[2] & ~s3[2];
  assign stb_rise = s2[1] & ~s3[1];
  assign oeb_fall = ~s2[0] & s3[0];
  assign row_a    = s2[ADDR_W+2:3];
  assign din      = s2[DOFS +: 6];

  logic [5:0][COLS-1:0] sh, sh_nxt, lat, row_src;
  logic [CNT_W-1:0]     shift_cnt, cnt_nxt;
  logic                 latch_valid;

  always_comb begin
    sh_nxt  = sh;
    cnt_nxt = shift_cnt;
    if (clk_rise) begin
      for (int i = 0; i < 6; i++) sh_nxt[i] = {sh[i][COLS-2:0], din[i]};
      cnt_nxt = sat_inc(shift_cnt);
    end
    // A latch in the same cycle as the commit must hand over the fresh data.
    row_src = stb_rise ? sh_nxt : lat;
    commit  = oeb_fall && ((COMMIT_ONCE == 0) || latch_valid || stb_rise);
  end

  // Synchroniser, shift, latch and commit control
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      sh           <= '0;
      lat          <= '0;
      shift_cnt    <= '0;
      latch_valid  <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      row_commit   <= 1'b0;
      frame_done   <= 1'b0;
      commit_count <= '0;
    end else begin
      s1        <= pins;
      s2        <= s1;
      s3        <= s2[2:0];
      sh        <= sh_nxt;
      shift_cnt <= cnt_nxt;
      if (stb_rise) begin
        lat         <= sh_nxt;
        shift_cnt   <= '0;
        latch_valid <= 1'b1;
        if (cnt_nxt < CNT_FULL) err_short <= 1'b1;
        if (cnt_nxt > CNT_FULL) err_long  <= 1'b1;
      end
      row_commit <= commit;
      frame_done <= commit && (row_a == LAST_ROW);
      if (commit) begin
        commit_count <= commit_count + 16'd1;
        if (COMMIT_ONCE != 0) latch_valid <= 1'b0;
      end
    end
  end

  // Frame store: per row, [2]=R [1]=G [0]=B, column 0 at bit COLS-1
  logic [2:0][COLS-1:0] fb [2*SCAN];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < 2*SCAN; r++) fb[r] <= '0;
    end else if (commit) begin
      fb[{1'b0, row_a}] <= {row_src[0], row_src[1], row_src[2]};
      fb[{1'b1, row_a}] <= {row_src[3], row_src[4], row_src[5]};
    end
  end

  // Readback stage
  logic [COL_W-1:0] bit_idx;
  logic [2:0]       rd_pix;

  always_comb begin
    bit_idx = LAST_COL - rd_col;
    rd_pix  = '0;
    if ({1'b0, rd_col} < COL_LIM)
      rd_pix = {fb[rd_row][2][bit_idx], fb[rd_row][1][bit_idx], fb[rd_row][0][bit_idx]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_rgb <= '0;
    else     rd_rgb <= rd_pix;
  end

endmodule

// File: tb/tb_hub75_panel_capture.sv
// Randomised bench for hub75_panel_capture: panel-side driver, frame-level
// reference model and a scoreboard that checks every commit pulse.
module tb_hub75_panel_capture;
  localparam int COLS = 64, SCAN = 16, ADDR_W = 4, COL_W = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic P_R1, P_G1, P_B1, P_R2, P_G2, P_B2;
  logic [ADDR_W-1:0] P_ADDR;
  logic P_CLK, P_STB, P_OEB;
  logic [ADDR_W:0]  rd_row;
  logic [COL_W-1:0] rd_col;
  logic [2:0]  rd_rgb, rd_rgb0;
  logic        row_commit, frame_done, err_short, err_long;
  logic        row_commit0, frame_done0, err_short0, err_long0;
  logic [15:0] commit_count, commit_count0;

  always #5 CLK = ~CLK;

  hub75_panel_capture #(.COLS(COLS), .SCAN(SCAN), .ADDR_W(ADDR_W), .COL_W(COL_W), .COMMIT_ONCE(1)) dut (
    .CLK(CLK), .RST(RST),
    .P_R1(P_R1), .P_G1(P_G1), .P_B1(P_B1), .P_R2(P_R2), .P_G2(P_G2), .P_B2(P_B2),
    .P_ADDR(P_ADDR), .P_CLK(P_CLK), .P_STB(P_STB), .P_OEB(P_OEB),
    .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
    .row_commit(row_commit), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .commit_count(commit_count));

  // Second instance sees the same pins but commits on every OEb fall.
  hub75_panel_capture #(.COLS(COLS), .SCAN(SCAN), .ADDR_W(ADDR_W), .COL_W(COL_W), .COMMIT_ONCE(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .P_R1(P_R1), .P_G1(P_G1), .P_B1(P_B1), .P_R2(P_R2), .P_G2(P_G2), .P_B2(P_B2),
    .P_ADDR(P_ADDR), .P_CLK(P_CLK), .P_STB(P_STB), .P_OEB(P_OEB),
    .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb0),
    .row_commit(row_commit0), .frame_done(frame_done0),
    .err_short(err_short0), .err_long(err_long0), .commit_count(commit_count0));

  // Reference model: sample history (bit0=R1 .. bit5=B2), latch, frame, counters.
  logic [5:0]  hq [$];
  logic [5:0]  m_lat [COLS];
  logic [2:0]  m_fb [2*SCAN][COLS];
  bit          m_lv, m_es, m_el;
  int          m_n;
  logic [15:0] m_cnt, m_cnt0;
  bit          exp_fd [$];
  logic [15:0] exp_cc [$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    repeat (COLS) hq.push_back(6'd0);
    for (int c = 0; c < COLS; c++) m_lat[c] = '0;
    for (int r = 0; r < 2*SCAN; r++)
      for (int c = 0; c < COLS; c++) m_fb[r][c] = '0;
    m_lv = 0; m_es = 0; m_el = 0; m_n = 0;
    m_cnt = '0; m_cnt0 = '0;
    exp_fd.delete();
    exp_cc.delete();
  endtask

  task automatic m_push(input logic [5:0] s);
    hq.push_back(s);
    void'(hq.pop_front());
    m_n++;
  endtask

  task automatic m_latch();
    for (int c = 0; c < COLS; c++) m_lat[c] = hq[c];
    if (m_n < COLS) m_es = 1;
    if (m_n > COLS) m_el = 1;
    m_n  = 0;
    m_lv = 1;
  endtask

  task automatic m_commit(input int a);
    m_cnt0++;
    if (m_lv) begin
      for (int c = 0; c < COLS; c++) begin
        m_fb[a][c]      = {m_lat[c][0], m_lat[c][1], m_lat[c][2]};
        m_fb[a+SCAN][c] = {m_lat[c][3], m_lat[c][4], m_lat[c][5]};
      end
      m_lv = 0;
      m_cnt++;
      exp_fd.push_back(a == SCAN-1);
      exp_cc.push_back(m_cnt);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_data(input logic [5:0] s);
    {P_B2, P_G2, P_R2, P_B1, P_G1, P_R1} = s;
  endtask

  task automatic shift1(input logic [5:0] s);
    set_data(s); cycles(3);
    P_CLK = 1'b1; cycles(3);
    P_CLK = 1'b0;
    m_push(s);
  endtask

  task automatic shift_n(input int n, input logic [5:0] s, input bit rnd);
    for (int i = 0; i < n; i++) shift1(rnd ? 6'($urandom) : s);
  endtask

  task automatic latch();
    cycles(2);
    P_STB = 1'b1; cycles(3);
    P_STB = 1'b0; cycles(3);
    m_latch();
  endtask

  task automatic shift_and_latch(input logic [5:0] s);
    set_data(s); cycles(3);
    P_CLK = 1'b1; P_STB = 1'b1; cycles(3);
    P_CLK = 1'b0; P_STB = 1'b0; cycles(3);
    m_push(s);
    m_latch();
  endtask

  task automatic oe_fall(input int a);
    P_ADDR = ADDR_W'(a); cycles(3);
    m_commit(a);
    P_OEB = 1'b0; cycles(3);
    P_OEB = 1'b1; cycles(3);
  endtask

  task automatic latch_and_fall(input int a);
    P_ADDR = ADDR_W'(a); cycles(3);
    m_latch();
    m_commit(a);
    P_STB = 1'b1; P_OEB = 1'b0; cycles(3);
    P_STB = 1'b0; P_OEB = 1'b1; cycles(3);
  endtask

  task automatic chk_row(input int r);
    for (int c = 0; c < COLS; c++) begin
      rd_row = (ADDR_W+1)'(r);
      rd_col = COL_W'(c);
      @(negedge CLK);
      chk($sformatf("rd_rgb r%0d c%0d", r, c), 32'(rd_rgb), 32'(m_fb[r][c]));
    end
  endtask

  task automatic chk_flags();
    chk("err_short", 32'(err_short), 32'(m_es));
    chk("err_long", 32'(err_long), 32'(m_el));
    chk("commit_count", 32'(commit_count), 32'(m_cnt));
    chk("commit_count0", 32'(commit_count0), 32'(m_cnt0));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    cycles(3);
    RST = 1'b0;
    cycles(2);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_fd.size() != 0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("pending commits", 32'(exp_fd.size()), 32'd0);
  endtask

  task automatic monitor();
    bit          fd;
    logic [15:0] cc;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (row_commit) begin
          if (exp_fd.size() == 0) chk("row_commit unexpected", 32'(row_commit), 32'd0);
          else begin
            fd = exp_fd.pop_front();
            cc = exp_cc.pop_front();
            chk("frame_done", 32'(frame_done), 32'(fd));
            chk("commit_count at pulse", 32'(commit_count), 32'(cc));
          end
        end else begin
          chk("frame_done stray", 32'(frame_done), 32'd0);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int nsel [5] = '{63, 64, 64, 64, 65};
    set_data(6'd0);
    P_ADDR = '0; P_CLK = 1'b0; P_STB = 1'b0; P_OEB = 1'b1;
    rd_row = '0; rd_col = '0;
    model_reset();
    fork monitor(); join_none
    cycles(4);
    RST = 1'b0;
    cycles(2);

    chk("reset rd_rgb", 32'(rd_rgb), 32'd0);
    chk("reset row_commit", 32'(row_commit), 32'd0);
    chk_flags();

    // Alternating R1 pattern at address 3
    for (int i = 0; i < COLS; i++) shift1({5'd0, (i % 2 == 0)});
    latch();
    oe_fall(3);
    drain();
    chk_row(3);
    chk_row(19);
    chk_flags();

    // G2 and B1 solid at the last address -> frame_done
    shift_n(COLS, 6'b010100, 0);
    latch();
    oe_fall(SCAN-1);
    drain();
    chk_row(SCAN-1);
    chk_row(2*SCAN-1);
    chk_flags();

    // Final shift coincides with the strobe rise
    shift_n(COLS-1, 6'b001000, 0);
    shift_and_latch(6'b001000);
    oe_fall(5);
    drain();
    chk_row(5 + SCAN);
    chk_flags();

    // Strobe rise and OEb fall in the same cycle
    shift_n(COLS, 6'b000001, 0);
    latch_and_fall(7);
    drain();
    chk_row(7);
    chk_flags();

    // One latch, three OEb falls
    shift_n(COLS, 6'd0, 1);
    latch();
    repeat (3) oe_fall(9);
    drain();
    chk_row(9);
    chk_row(9 + SCAN);
    chk_flags();

    // Short and long shift counts, then reset clears the sticky flags
    shift_n(COLS-1, 6'd0, 1);
    latch();
    chk_flags();
    shift_n(COLS+1, 6'd0, 1);
    latch();
    chk_flags();
    do_reset();
    chk_flags();

    // Reset in the middle of a row
    shift_n(30, 6'd0, 1);
    do_reset();
    shift_n(COLS, 6'b000100, 0);
    latch();
    oe_fall(0);
    drain();
    chk_row(0);
    chk_flags();

    // Random rows, shift counts and OEb fall counts
    for (int it = 0; it < 12; it++) begin
      shift_n(nsel[$urandom_range(0, 4)], 6'd0, 1);
      latch();
      repeat ($urandom_range(0, 2)) oe_fall($urandom_range(0, SCAN-1));
      drain();
      chk_flags();
    end
    for (int r = 0; r < 2*SCAN; r++) chk_row(r);
    chk_flags();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
